// File: rtl/inst_prefetch_unit.sv
// inst_prefetch_unit: instruction front end.
//
// A direct-mapped instruction cache feeds a small circular fetch queue so that fetch
// runs ahead of the issuer. Line refills come from the memory controller through a
// single-outstanding request handshake. ROB redirects flush the queue and retarget fetch.
//
// Optional feature: define INST_NEXT_LINE_PREFETCH_EN to enable a next-line prefetcher.
// After a demand refill of line L it immediately requests L+LINE_BYTES if that line is
// not already resident. With the macro undefined, the PREFETCH state is not built.
//
// Reset is synchronous and active-high. rdy low freezes every register.

module inst_prefetch_unit #(
  parameter int unsigned LINE_BYTES  = 16,
  parameter int unsigned SETS        = 64,
  parameter int unsigned QUEUE_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  // memory controller side
  output logic                    valid_to_mem_ctrler,
  output logic [31:0]             addr_to_mem_ctrler,
  input  logic                    ready_from_mem_ctrler,
  input  logic [8*LINE_BYTES-1:0] cache_line_from_mem_ctrler,
  // issuer side
  output logic                    valid_to_issuer,
  input  logic                    ready_from_issuer,
  output logic [31:0]             pc_to_issuer,
  output logic [31:0]             next_pc_to_issuer,
  output logic [31:0]             inst_to_issuer,
  // ROB redirect
  input  logic                    reset_from_rob_bus,
  input  logic [31:0]             pc_from_rob_bus
);

  localparam int unsigned OffW  = $clog2(LINE_BYTES);
  localparam int unsigned IdxW  = $clog2(SETS);
  localparam int unsigned TagW  = 32 - OffW - IdxW;
  localparam int unsigned PtrW  = $clog2(QUEUE_DEPTH);
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned LineW = 8 * LINE_BYTES;

  localparam logic [CntW-1:0] QDepth = CntW'(QUEUE_DEPTH);

  typedef enum logic [1:0] {
    StIdle,
`ifdef INST_NEXT_LINE_PREFETCH_EN
    StRefill,
    StPrefetch
`else
    StRefill
`endif
  } state_e;

  // Fill FSM and request address
  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;

  // Fetch PC
  logic [31:0] fpc_q, fpc_d;

  // Cache arrays
  logic [SETS-1:0]  valid_q, valid_d;
  logic [TagW-1:0]  tag_q  [SETS];
  logic [TagW-1:0]  tag_d  [SETS];
  logic [LineW-1:0] line_q [SETS];
  logic [LineW-1:0] line_d [SETS];

  // Fetch queue
  logic [31:0]     qpc_q   [QUEUE_DEPTH];
  logic [31:0]     qpc_d   [QUEUE_DEPTH];
  logic [31:0]     qnpc_q  [QUEUE_DEPTH];
  logic [31:0]     qnpc_d  [QUEUE_DEPTH];
  logic [31:0]     qinst_q [QUEUE_DEPTH];
  logic [31:0]     qinst_d [QUEUE_DEPTH];
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] count_q, count_d;

  // Fetch-side lookup
  logic [OffW-1:0] f_off;
  logic [IdxW-1:0] f_idx;
  logic [TagW-1:0] f_tag;
  logic            hit;
  logic [31:0]     f_inst;

  // Fill-side decode; the install target comes from the request address, not fpc,
  // so a refill that outlives a redirect still lands in the right set.
  logic [IdxW-1:0] fill_idx;
  logic [TagW-1:0] fill_tag;
  logic            fill_done;

  logic q_empty;
  logic push;
  logic pop;

  assign f_off  = fpc_q[OffW-1:0];
  assign f_idx  = fpc_q[OffW +: IdxW];
  assign f_tag  = fpc_q[OffW+IdxW +: TagW];
  assign hit    = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
  assign f_inst = line_q[f_idx][{f_off, 3'b000} +: 32];

  assign fill_idx  = addr_q[OffW +: IdxW];
  assign fill_tag  = addr_q[OffW+IdxW +: TagW];
  assign fill_done = ready_from_mem_ctrler && (state_q != StIdle);

  assign q_empty = (count_q == '0);
  // Redirect wins over both push and pop.
  assign pop     = !q_empty && ready_from_issuer && !reset_from_rob_bus;
  assign push    = hit && !reset_from_rob_bus && ((count_q < QDepth) || pop);

`ifdef INST_NEXT_LINE_PREFETCH_EN
  logic [31:0]     pf_addr;
  logic [IdxW-1:0] pf_idx;
  logic [TagW-1:0] pf_tag;
  logic            pf_hit;

  assign pf_addr = addr_q + 32'(LINE_BYTES);
  assign pf_idx  = pf_addr[OffW +: IdxW];
  assign pf_tag  = pf_addr[OffW+IdxW +: TagW];
  assign pf_hit  = valid_q[pf_idx] && (tag_q[pf_idx] == pf_tag);
`endif

  // Fill FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
    end else if (rdy) begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  // Fill FSM next state: request on a miss, hold the request until the ready pulse
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    unique case (state_q)
      StIdle: begin
        if (!hit && !reset_from_rob_bus) begin
          state_d = StRefill;
          addr_d  = {fpc_q[31:OffW], {OffW{1'b0}}};
        end
      end
      StRefill: begin
        if (ready_from_mem_ctrler) begin
`ifdef INST_NEXT_LINE_PREFETCH_EN
          if (!pf_hit) begin
            state_d = StPrefetch;
            addr_d  = pf_addr;
          end else begin
            state_d = StIdle;
          end
`else
          state_d = StIdle;
`endif
        end
      end
`ifdef INST_NEXT_LINE_PREFETCH_EN
      StPrefetch: begin
        if (ready_from_mem_ctrler) begin
          state_d = StIdle;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  // Fill FSM outputs: a request is pending in every non-idle state
  always_comb begin
    valid_to_mem_ctrler = (state_q != StIdle);
    addr_to_mem_ctrler  = addr_q;
  end

  // Cache install, fetch PC and queue next state
  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    line_d   = line_q;
    qpc_d    = qpc_q;
    qnpc_d   = qnpc_q;
    qinst_d  = qinst_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    fpc_d    = fpc_q;

    if (fill_done) begin
      valid_d[fill_idx] = 1'b1;
      tag_d[fill_idx]   = fill_tag;
      line_d[fill_idx]  = cache_line_from_mem_ctrler;
    end

    if (reset_from_rob_bus) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      fpc_d    = pc_from_rob_bus;
    end else begin
      if (push) begin
        qpc_d[wr_ptr_q]   = fpc_q;
        qnpc_d[wr_ptr_q]  = fpc_q + 32'd4;
        qinst_d[wr_ptr_q] = f_inst;
        wr_ptr_d          = wr_ptr_q + 1'b1;
        fpc_d             = fpc_q + 32'd4;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Cache, fetch PC and queue registers
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= '0;
      fpc_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < SETS; i++) begin
        tag_q[i]  <= '0;
        line_q[i] <= '0;
      end
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        qpc_q[i]   <= '0;
        qnpc_q[i]  <= '0;
        qinst_q[i] <= '0;
      end
    end else if (rdy) begin
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      line_q   <= line_d;
      fpc_q    <= fpc_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      qpc_q    <= qpc_d;
      qnpc_q   <= qnpc_d;
      qinst_q  <= qinst_d;
    end
  end

  // Issuer outputs: queue head, forced to zero while the queue is empty
  always_comb begin
    valid_to_issuer   = !q_empty;
    pc_to_issuer      = '0;
    next_pc_to_issuer = '0;
    inst_to_issuer    = '0;
    if (!q_empty) begin
      pc_to_issuer      = qpc_q[rd_ptr_q];
      next_pc_to_issuer = qnpc_q[rd_ptr_q];
      inst_to_issuer    = qinst_q[rd_ptr_q];
    end
  end

endmodule

// File: tb/tb_inst_prefetch_unit.sv
// Bench for inst_prefetch_unit (LINE_BYTES=16, SETS=64, QUEUE_DEPTH=4).
// Memory model: the word at address a holds a, so every fetched instruction equals its PC.
// Expected request addresses and issued PCs go into queues; a memory process and an
// issuer monitor pop and compare them as the DUT presents requests and handshakes.

module tb_inst_prefetch_unit;

  localparam int unsigned LB = 16;
  localparam int unsigned NS = 64;
  localparam int unsigned QD = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rdy = 1'b1;
  logic          valid_to_mem_ctrler;
  logic [31:0]   addr_to_mem_ctrler;
  logic          ready_from_mem_ctrler = 1'b0;
  logic [8*LB-1:0] cache_line_from_mem_ctrler = '0;
  logic          valid_to_issuer;
  logic          ready_from_issuer = 1'b0;
  logic [31:0]   pc_to_issuer;
  logic [31:0]   next_pc_to_issuer;
  logic [31:0]   inst_to_issuer;
  logic          reset_from_rob_bus = 1'b0;
  logic [31:0]   pc_from_rob_bus = '0;

  int checks = 0;
  int errors = 0;
  int mem_lat = 2;

  logic [31:0] exp_req[$];
  logic [31:0] exp_pc[$];

  always #5 clk = ~clk;

  inst_prefetch_unit #(
    .LINE_BYTES (LB),
    .SETS       (NS),
    .QUEUE_DEPTH(QD)
  ) dut (
    .clk                       (clk),
    .rst                       (rst),
    .rdy                       (rdy),
    .valid_to_mem_ctrler       (valid_to_mem_ctrler),
    .addr_to_mem_ctrler        (addr_to_mem_ctrler),
    .ready_from_mem_ctrler     (ready_from_mem_ctrler),
    .cache_line_from_mem_ctrler(cache_line_from_mem_ctrler),
    .valid_to_issuer           (valid_to_issuer),
    .ready_from_issuer         (ready_from_issuer),
    .pc_to_issuer              (pc_to_issuer),
    .next_pc_to_issuer         (next_pc_to_issuer),
    .inst_to_issuer            (inst_to_issuer),
    .reset_from_rob_bus        (reset_from_rob_bus),
    .pc_from_rob_bus           (pc_from_rob_bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%h, required 0x%h", name, act, exp);
    end
  endtask

  function automatic logic [8*LB-1:0] make_line(input logic [31:0] a);
    logic [8*LB-1:0] r;
    r = '0;
    for (int i = 0; i < int'(LB / 4); i++) begin
      r[i*32 +: 32] = a + 32'(4 * i);
    end
    return r;
  endfunction

  // Memory controller model: one request at a time, ready pulse after mem_lat cycles
  initial begin : mem_model
    logic [31:0] a;
    forever begin
      @(negedge clk);
      if (!rst && valid_to_mem_ctrler) begin
        a = addr_to_mem_ctrler;
        if (exp_req.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL mem_req_unexpected: got request 0x%h, required none", a);
        end else begin
          chk("mem_req_addr", a, exp_req.pop_front());
        end
        repeat (mem_lat) @(posedge clk);
        #1;
        chk("mem_req_held", addr_to_mem_ctrler, a);
        cache_line_from_mem_ctrler = make_line(a);
        ready_from_mem_ctrler      = 1'b1;
        @(posedge clk);
        #1;
        ready_from_mem_ctrler = 1'b0;
      end
    end
  end

  // Issuer monitor: every accepted head is compared against the expected PC stream
  initial begin : issue_monitor
    logic [31:0] p;
    forever begin
      @(negedge clk);
      if (!rst && rdy && valid_to_issuer && ready_from_issuer && !reset_from_rob_bus) begin
        checks++;
        if (exp_pc.size() == 0) begin
          errors++;
          $display("FAIL issue_unexpected: got pc 0x%h, required no issue", pc_to_issuer);
        end else begin
          p = exp_pc.pop_front();
          if (pc_to_issuer !== p || next_pc_to_issuer !== p + 32'd4 || inst_to_issuer !== p) begin
            errors++;
            $display("FAIL issue_head: got pc 0x%h npc 0x%h inst 0x%h, required 0x%h 0x%h 0x%h",
                     pc_to_issuer, next_pc_to_issuer, inst_to_issuer, p, p + 32'd4, p);
          end
        end
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic redirect(input logic [31:0] target);
    @(posedge clk);
    #1;
    reset_from_rob_bus = 1'b1;
    pc_from_rob_bus    = target;
    @(posedge clk);
    #1;
    reset_from_rob_bus = 1'b0;
  endtask

  task automatic push_pcs(input logic [31:0] first, input int n);
    for (int i = 0; i < n; i++) exp_pc.push_back(first + 32'(4 * i));
  endtask

  // Hold issuer ready until exactly k heads have been accepted
  task automatic consume(input int k);
    int n;
    int cyc;
    n   = 0;
    cyc = 0;
    @(posedge clk);
    #1;
    ready_from_issuer = 1'b1;
    while (n < k && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (valid_to_issuer && rdy) n++;
    end
    @(posedge clk);
    #1;
    ready_from_issuer = 1'b0;
    chk("consume_count", 32'(n), 32'(k));
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int n;

    // Cold start: line 0x0 then 0x10 while the queue fills and stalls
    exp_req.push_back(32'h0);
    exp_req.push_back(32'h10);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_valid_to_mem", 32'(valid_to_mem_ctrler), 32'd0);
    chk("rst_addr_to_mem", addr_to_mem_ctrler, 32'h0);
    chk("rst_valid_to_issuer", 32'(valid_to_issuer), 32'd0);
    chk("rst_pc", pc_to_issuer, 32'h0);
    chk("rst_next_pc", next_pc_to_issuer, 32'h0);
    chk("rst_inst", inst_to_issuer, 32'h0);
    @(negedge clk);
    chk("miss_req_valid", 32'(valid_to_mem_ctrler), 32'd1);
    chk("miss_req_addr", addr_to_mem_ctrler, 32'h0);
    n = 0;
    while (!ready_from_mem_ctrler && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("refill_ready_seen", 32'(ready_from_mem_ctrler), 32'd1);
    @(negedge clk);
    chk("issue_latency_r1", 32'(valid_to_issuer), 32'd0);
    @(negedge clk);
    chk("issue_latency_r2", 32'(valid_to_issuer), 32'd1);
    chk("issue_first_pc", pc_to_issuer, 32'h0);
    cycles(20);
    @(negedge clk);
    chk("full_valid", 32'(valid_to_issuer), 32'd1);
    chk("full_head_pc", pc_to_issuer, 32'h0);
    chk("full_head_npc", next_pc_to_issuer, 32'h4);
    chk("full_head_inst", inst_to_issuer, 32'h0);
    chk("cold_reqs_done", 32'(exp_req.size()), 32'd0);

    // rdy low: issuer ready is ignored and nothing moves
    @(posedge clk);
    #1;
    rdy               = 1'b0;
    ready_from_issuer = 1'b1;
    cycles(3);
    #1;
    rdy               = 1'b1;
    ready_from_issuer = 1'b0;
    @(negedge clk);
    chk("rdy_hold_valid", 32'(valid_to_issuer), 32'd1);
    chk("rdy_hold_pc", pc_to_issuer, 32'h0);

    // Drain in order past the line boundary; 0x20 misses as fetch runs ahead
    exp_req.push_back(32'h20);
`ifdef INST_NEXT_LINE_PREFETCH_EN
    exp_req.push_back(32'h30);
`endif
    push_pcs(32'h0, 6);
    consume(6);
    cycles(20);
    @(negedge clk);
    chk("drain_head_pc", pc_to_issuer, 32'h18);

    // Redirect with a full queue: flushed next cycle, new path from 0x40
    exp_req.push_back(32'h40);
    exp_req.push_back(32'h50);
    redirect(32'h40);
    @(negedge clk);
    chk("redirect_flush", 32'(valid_to_issuer), 32'd0);
    cycles(20);
    push_pcs(32'h40, 2);
    consume(2);
    cycles(20);

    // Redirect to 0x80 while the 0x60 refill is outstanding
    mem_lat = 8;
    exp_req.push_back(32'h60);
`ifdef INST_NEXT_LINE_PREFETCH_EN
    exp_req.push_back(32'h70);
`endif
    exp_req.push_back(32'h80);
    exp_req.push_back(32'h90);
    redirect(32'h60);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!valid_to_mem_ctrler && n < 20);
    chk("refill60_pending", 32'(valid_to_mem_ctrler), 32'd1);
    chk("refill60_addr", addr_to_mem_ctrler, 32'h60);
    redirect(32'h80);
    cycles(60);
    chk("refill_after_redirect_reqs", 32'(exp_req.size()), 32'd0);

    // Jump back to 0x60: installed despite the redirect, so it hits with no request
`ifndef INST_NEXT_LINE_PREFETCH_EN
    exp_req.push_back(32'h70);
`endif
    redirect(32'h60);
    @(negedge clk);
    chk("rehit_d1_valid", 32'(valid_to_issuer), 32'd0);
    @(negedge clk);
    chk("rehit_d2_valid", 32'(valid_to_issuer), 32'd1);
    chk("rehit_d2_pc", pc_to_issuer, 32'h60);
    chk("rehit_no_req", 32'(valid_to_mem_ctrler), 32'd0);
    cycles(30);
    push_pcs(32'h60, 5);
    consume(5);
    cycles(20);
    @(negedge clk);
    chk("line80_kept_head", pc_to_issuer, 32'h74);
    chk("line80_kept_noreq", 32'(valid_to_mem_ctrler), 32'd0);

    // Aliasing: 0x400 evicts 0x0 (same set), so returning to 0x0 re-requests it
    mem_lat = 2;
    exp_req.push_back(32'h400);
    exp_req.push_back(32'h410);
    redirect(32'h400);
    cycles(30);
    exp_req.push_back(32'h0);
    exp_req.push_back(32'h10);
    redirect(32'h0);
    cycles(30);
    push_pcs(32'h0, 4);
    consume(4);
    cycles(20);
    @(negedge clk);
    chk("alias_head_pc", pc_to_issuer, 32'h10);
    chk("alias_valid", 32'(valid_to_issuer), 32'd1);
    chk("alias_noreq", 32'(valid_to_mem_ctrler), 32'd0);

    chk("final_req_queue_empty", 32'(exp_req.size()), 32'd0);
    chk("final_pc_queue_empty", 32'(exp_pc.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_prefetch_unit.md
# inst_prefetch_unit

Parametrised instruction front end. A direct-mapped instruction cache with configurable line size and set count feeds a QUEUE_DEPTH-entry fetch queue, so fetch runs ahead of the issuer. Redirects from the ROB bus flush the queue. An optional next-line prefetcher is available. It sits between the memory controller (line refills) and the issuer (valid/ready instruction stream).

## Interface
Parameters:
- LINE_BYTES, 16, bytes per cache line; power of two, ≥4
- SETS, 64, number of direct-mapped sets; power of two, ≥2
- QUEUE_DEPTH, 4, fetch queue entries; power of two, ≥2

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- rdy  in  1  global enable; when low, no register changes and `ready_from_mem_ctrler` is ignored
- valid_to_mem_ctrler  out  1  line request pending
- addr_to_mem_ctrler  out  32  line-aligned request address
- ready_from_mem_ctrler  in  1  one-cycle pulse; line data valid
- cache_line_from_mem_ctrler  in  8*LINE_BYTES  line data, byte 0 in bits [7:0]
- valid_to_issuer  out  1  queue head valid
- ready_from_issuer  in  1  issuer accepts head
- pc_to_issuer  out  32  head PC
- next_pc_to_issuer  out  32  head PC+4
- inst_to_issuer  out  32  head instruction, little-endian
- reset_from_rob_bus  in  1  redirect/flush
- pc_from_rob_bus  in  32  redirect target

## Operation
- Address split: offset = pc[log2(LINE_BYTES)-1:0]; index = next log2(SETS) bits; tag = remaining upper bits. PC is always 4-aligned, so an instruction never crosses a line.
- Hit: valid[index] set and tag[index] matches the tag of the fetch PC `fpc`.
- Push on a cycle when all of the following hold: hit, no redirect, and the queue has room (count<QUEUE_DEPTH, or a pop occurs the same cycle).
  - The pushed entry is {fpc, fpc+4, inst}.
  - fpc then advances by 4.
- Pop when valid_to_issuer && ready_from_issuer. Push and pop in the same cycle leave count unchanged, including when the queue is full.
- Queue: circular buffer. Read/write pointers are log2(QUEUE_DEPTH) bits and wrap naturally. count is log2(QUEUE_DEPTH)+1 bits.
- Redirect (reset_from_rob_bus=1):
  - count, rd_ptr, wr_ptr go to 0.
  - fpc <= pc_from_rob_bus.
  - No push or pop occurs that cycle; redirect wins over both.
- Fill FSM states: IDLE, REFILL, PREFETCH.
  - IDLE -> REFILL: on a miss with no redirect. addr <= {fpc line-aligned}; valid_to_mem_ctrler <= 1.
  - REFILL -> IDLE: on ready_from_mem_ctrler. The line is written to the set, tag and valid bit derived from addr_to_mem_ctrler, not from fpc, so a refill that completes after a redirect is still installed. valid_to_mem_ctrler <= 0.
  - REFILL -> PREFETCH: only when the prefetch macro is defined (see Configuration).
  - PREFETCH -> IDLE: on ready_from_mem_ctrler, installing the line the same way as REFILL.
- Request rule: addr_to_mem_ctrler and valid_to_mem_ctrler are held stable from assertion until the ready pulse. At most one request is outstanding.
- A redirect during REFILL or PREFETCH does not cancel the request. After it completes, IDLE re-evaluates the hit against the new fpc.
- Reset:
  - All valid bits, tags and lines are cleared.
  - fpc=0, state=IDLE, queue empty.
  - valid_to_mem_ctrler=0, addr_to_mem_ctrler=0, valid_to_issuer=0.
  - pc_to_issuer, next_pc_to_issuer and inst_to_issuer read 0 while the queue is empty.
  - A reset asserted mid-refill abandons the request. The memory controller shares rst.

## Timing
- Hit push at edge N: valid_to_issuer=1 from cycle N+1. Steady-state throughput is one instruction per cycle.
- Miss detected in cycle M: valid_to_mem_ctrler=1 from M+1. When ready arrives in cycle R, the line is installed at edge R, the hit is seen in R+1, and valid_to_issuer=1 in R+2.
- Redirect in cycle D: valid_to_issuer=0 in D+1. The first new-path push happens at edge D+1 on a hit.
- Queue-full stall: fpc holds and nothing is pushed, while the miss/hit logic still runs.

## Configuration
- Macro: INST_NEXT_LINE_PREFETCH_EN.
- Defined: on completion of REFILL for line L, if line L+LINE_BYTES is not a hit in its set, go to PREFETCH and request it immediately. The address is presented the cycle after the refill ready, with valid kept high. Otherwise go to IDLE.
- Undefined: REFILL always returns to IDLE, and the PREFETCH state and its logic are absent.

## Test plan
- Cold start from rst, LINE_BYTES=16, memory word at address a holds a: request addr 0x0. After ready, pc_to_issuer emits 0,4,8,0xC with inst = 0,4,8,0xC, then a request for addr 0x10.
- Issuer ready held 0: exactly QUEUE_DEPTH=4 entries accepted, fpc stalls at 0x10. Then ready held 1: heads pop in order 0,4,8,0xC with no loss.
- Redirect to 0x40 while the queue holds 3 entries: valid_to_issuer=0 next cycle, then the next head PC is 0x40.
- Redirect to 0x80 during an outstanding refill of 0x20: line 0x20 is installed anyway, then a request for 0x80 follows. A later jump to 0x20 hits without a request.
- INST_NEXT_LINE_PREFETCH_EN defined, miss at 0x100: requests 0x100 then 0x110 back-to-back, and fetch crosses into 0x110 with no further request.
- Aliasing with SETS=64, LINE_BYTES=16: fetch 0x0, then a redirect to 0x400 evicts it, then a redirect to 0x0 re-requests 0x0.
